// File: rtl/mem_req_arbiter_if.sv
// Bundle of the two-requester upstream bus, the shared downstream port and arbiter status.
// The slave modport is the arbiter's view; master is the environment that drives it.
interface mem_req_arbiter_if;
    logic [1:0]  u_req;
    logic [1:0]  u_wr;
    logic [63:0] u_addr;
    logic [63:0] u_wdata;
    logic [7:0]  u_wstrb;
    logic [31:0] u_rdata;
    logic [1:0]  u_ready;
    logic [1:0]  u_error;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_error;
    logic [1:0]  grant;
    logic        busy;

    modport slave (
        input  u_req, u_wr, u_addr, u_wdata, u_wstrb, d_rdata, d_ready, d_error,
        output u_rdata, u_ready, u_error, d_req, d_wr, d_addr, d_wdata, d_wstrb, grant, busy
    );

    modport master (
        output u_req, u_wr, u_addr, u_wdata, u_wstrb, d_rdata, d_ready, d_error,
        input  u_rdata, u_ready, u_error, d_req, d_wr, d_addr, d_wdata, d_wstrb, grant, busy
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-requester arbiter sharing one simple-bus memory port, with round-robin or
// fixed-priority selection, registered issue and a per-transaction timeout.
module mem_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int FIXED_PRIO     = 0,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    mem_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TIMEOUT_EN_C = (TIMEOUT_CYCLES != 32'sd0);
    localparam bit               FIXED_C      = (FIXED_PRIO != 32'sd0);

    state_t           state_r;
    logic             last_grant_r;
    logic             owner_r;
    logic [CNT_W-1:0] cnt_r;
    logic             winner_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             timeout_s;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Pick the winner among current requesters; ties go to the other side of last_grant in round-robin mode.
    always_comb begin
        winner_s = 1'b0;
        case (bus.u_req)
            2'b01:   winner_s = 1'b0;
            2'b10:   winner_s = 1'b1;
            2'b11:   winner_s = FIXED_C ? 1'b0 : ~last_grant_r;
            default: winner_s = 1'b0;
        endcase
    end

    // Timeout fires on the BUSY cycle whose incremented count hits the limit; equality means no wrap path.
    always_comb begin
        cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        timeout_s  = TIMEOUT_EN_C && (cnt_next_s == TIMEOUT_C);
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            bus.d_req    <= 1'b0;
            bus.d_wr     <= 1'b0;
            bus.d_addr   <= 32'h0000_0000;
            bus.d_wdata  <= 32'h0000_0000;
            bus.d_wstrb  <= 4'b0000;
            bus.u_rdata  <= 32'h0000_0000;
            bus.u_ready  <= 2'b00;
            bus.u_error  <= 2'b00;
            bus.grant    <= 2'b00;
            bus.busy     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.u_req != 2'b00) begin
                        owner_r      <= winner_s;
                        last_grant_r <= winner_s;
                        cnt_r        <= {CNT_W{1'b0}};
                        bus.d_req    <= 1'b1;
                        bus.d_wr     <= winner_s ? bus.u_wr[1]        : bus.u_wr[0];
                        bus.d_addr   <= winner_s ? bus.u_addr[63:32]  : bus.u_addr[31:0];
                        bus.d_wdata  <= winner_s ? bus.u_wdata[63:32] : bus.u_wdata[31:0];
                        bus.d_wstrb  <= winner_s ? bus.u_wstrb[7:4]   : bus.u_wstrb[3:0];
                        bus.grant    <= onehot(winner_s);
                        bus.busy     <= 1'b1;
                        state_r      <= BUSY;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                BUSY: begin
                    if (bus.d_ready) begin
                        bus.d_req   <= 1'b0;
                        bus.u_rdata <= bus.d_rdata;
                        bus.u_ready <= onehot(owner_r);
                        bus.u_error <= bus.d_error ? onehot(owner_r) : 2'b00;
                        state_r     <= RESP;
                    end else if (timeout_s) begin
                        bus.d_req   <= 1'b0;
                        bus.u_rdata <= 32'h0000_0000;
                        bus.u_ready <= onehot(owner_r);
                        bus.u_error <= onehot(owner_r);
                        state_r     <= RESP;
                    end else begin
                        cnt_r       <= cnt_next_s;
                    end
                end
                RESP: begin
                    bus.u_ready <= 2'b00;
                    bus.u_error <= 2'b00;
                    bus.grant   <= 2'b00;
                    bus.busy    <= 1'b0;
                    cnt_r       <= {CNT_W{1'b0}};
                    state_r     <= IDLE;
                end
                default: begin
                    bus.d_req   <= 1'b0;
                    bus.u_ready <= 2'b00;
                    bus.u_error <= 2'b00;
                    bus.grant   <= 2'b00;
                    bus.busy    <= 1'b0;
                    cnt_r       <= {CNT_W{1'b0}};
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: scoreboard queues of expected issues and
// completions, with a round-robin instance and a fixed-priority instance run in lockstep.
module tb_mem_req_arbiter;

    typedef struct packed {
        logic [1:0]  grant;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } issue_t;

    typedef struct packed {
        logic [1:0]  ready;
        logic [1:0]  error;
        logic [31:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic prev_dreq = 1'b0;
    issue_t issue_q[$];
    resp_t  resp_q[$];
    issue_t ie;
    resp_t  re;

    mem_req_arbiter_if bus0();
    mem_req_arbiter_if bus1();

    mem_req_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    mem_req_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    assign bus1.u_req   = bus0.u_req;
    assign bus1.u_wr    = bus0.u_wr;
    assign bus1.u_addr  = bus0.u_addr;
    assign bus1.u_wdata = bus0.u_wdata;
    assign bus1.u_wstrb = bus0.u_wstrb;
    assign bus1.d_rdata = bus0.d_rdata;
    assign bus1.d_ready = bus0.d_ready;
    assign bus1.d_error = bus0.d_error;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare each new downstream issue and each completion pulse against the queues.
    always @(negedge clk) begin
        if (bus0.d_req === 1'b1 && prev_dreq === 1'b0) begin
            chk("issue_pending", 64'(issue_q.size() != 0), 64'd1);
            if (issue_q.size() != 0) begin
                ie = issue_q.pop_front();
                chk("issue_grant", 64'(bus0.grant),   64'(ie.grant));
                chk("issue_wr",    64'(bus0.d_wr),    64'(ie.wr));
                chk("issue_addr",  64'(bus0.d_addr),  64'(ie.addr));
                chk("issue_wdata", 64'(bus0.d_wdata), 64'(ie.wdata));
                chk("issue_wstrb", 64'(bus0.d_wstrb), 64'(ie.wstrb));
            end
        end
        if (bus0.u_ready !== 2'b00) begin
            chk("resp_pending", 64'(resp_q.size() != 0), 64'd1);
            if (resp_q.size() != 0) begin
                re = resp_q.pop_front();
                chk("resp_ready", 64'(bus0.u_ready), 64'(re.ready));
                chk("resp_error", 64'(bus0.u_error), 64'(re.error));
                chk("resp_rdata", 64'(bus0.u_rdata), 64'(re.rdata));
            end
        end
        prev_dreq <= bus0.d_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dreq(input string tag);
        int n = 0;
        @(negedge clk);
        while (bus0.d_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_dreq_seen"}, 64'(bus0.d_req), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (bus0.busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_seen"}, 64'(bus0.busy), 64'd0);
    endtask

    task automatic pulse_dready(input logic [31:0] rd, input logic err);
        bus0.d_ready = 1'b1;
        bus0.d_rdata = rd;
        bus0.d_error = err;
        step();
        bus0.d_ready = 1'b0;
        bus0.d_error = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       model_last;
        logic       g;
        int         last_ready_cyc;
        int         n;

        reset = 1'b1;
        bus0.u_req = 2'b00; bus0.u_wr = 2'b00; bus0.u_addr = 64'h0;
        bus0.u_wdata = 64'h0; bus0.u_wstrb = 8'h00;
        bus0.d_rdata = 32'h0; bus0.d_ready = 1'b0; bus0.d_error = 1'b0;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_d_req",  64'(bus0.d_req),   64'd0);
        chk("rst_grant",  64'(bus0.grant),   64'd0);
        chk("rst_busy",   64'(bus0.busy),    64'd0);
        chk("rst_u_ready", 64'(bus0.u_ready), 64'd0);
        chk("rst_d_addr", 64'(bus0.d_addr),  64'd0);
        chk("rst_d_wdata", 64'(bus0.d_wdata), 64'd0);
        chk("rst_misc", 64'({bus0.d_wr, bus0.d_wstrb, bus0.u_error, bus0.u_rdata}), 64'd0);

        // Single read from requester 0, d_ready three cycles after d_req.
        step();
        bus0.u_req = 2'b01; bus0.u_wr = 2'b00;
        bus0.u_addr = {32'h0, 32'h0000_0100}; bus0.u_wdata = 64'h0; bus0.u_wstrb = 8'h00;
        issue_q.push_back(issue_t'{grant: 2'b01, wr: 1'b0, addr: 32'h0000_0100, wdata: 32'h0, wstrb: 4'h0});
        resp_q.push_back(resp_t'{ready: 2'b01, error: 2'b00, rdata: 32'hDEAD_BEEF});
        @(negedge clk);
        chk("t1_no_early_dreq", 64'(bus0.d_req), 64'd0);
        step();
        bus0.u_req = 2'b00;
        @(negedge clk);
        chk("t1_latency", 64'(bus0.d_req), 64'd1);
        step();
        step();
        @(negedge clk);
        chk("t1_hold", 64'({bus0.d_req, bus0.d_addr}), 64'({1'b1, 32'h0000_0100}));
        step();
        pulse_dready(32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("t1_ready_cycle", 64'(bus0.u_ready), 64'd1);
        wait_idle("t1");
        chk("t1_grant_clear", 64'(bus0.grant), 64'd0);

        // Write from requester 1; fields must be held until d_ready.
        step();
        bus0.u_req = 2'b10; bus0.u_wr = 2'b10;
        bus0.u_addr = {32'h2000_0004, 32'h0}; bus0.u_wdata = {32'h1234_5678, 32'h0};
        bus0.u_wstrb = {4'b0011, 4'b0000};
        issue_q.push_back(issue_t'{grant: 2'b10, wr: 1'b1, addr: 32'h2000_0004, wdata: 32'h1234_5678, wstrb: 4'b0011});
        resp_q.push_back(resp_t'{ready: 2'b10, error: 2'b00, rdata: 32'hCAFE_F00D});
        wait_dreq("t2");
        step();
        bus0.u_req = 2'b00;
        bus0.u_addr = 64'h0; bus0.u_wdata = 64'h0; bus0.u_wstrb = 8'h00; bus0.u_wr = 2'b00;
        step();
        @(negedge clk);
        chk("t2_hold_addr", 64'(bus0.d_addr), 64'h2000_0004);
        chk("t2_hold_ctl", 64'({bus0.d_req, bus0.d_wr, bus0.d_wstrb, bus0.d_wdata}),
            64'({1'b1, 1'b1, 4'b0011, 32'h1234_5678}));
        step();
        pulse_dready(32'hCAFE_F00D, 1'b0);
        wait_idle("t2");

        // Downstream error passes through to the owner.
        step();
        bus0.u_req = 2'b01; bus0.u_wr = 2'b00;
        bus0.u_addr = {32'h0, 32'h0000_0200}; bus0.u_wdata = 64'h0; bus0.u_wstrb = 8'h00;
        issue_q.push_back(issue_t'{grant: 2'b01, wr: 1'b0, addr: 32'h0000_0200, wdata: 32'h0, wstrb: 4'h0});
        resp_q.push_back(resp_t'{ready: 2'b01, error: 2'b01, rdata: 32'h0BAD_0BAD});
        wait_dreq("t3");
        step();
        bus0.u_req = 2'b00;
        pulse_dready(32'h0BAD_0BAD, 1'b1);
        wait_idle("t3");

        // Contention with both requests held; reset first so requester 0 wins the first tie.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_last = 1'b1;
        bus0.u_wr = 2'b00;
        bus0.u_addr = {32'h1000_0010, 32'h0000_0010};
        bus0.u_wdata = {32'h1111_1111, 32'h2222_2222};
        bus0.u_wstrb = {4'hF, 4'h3};
        last_ready_cyc = 0;
        g = ~model_last;
        issue_q.push_back(issue_t'{grant: g ? 2'b10 : 2'b01, wr: 1'b0,
            addr: g ? 32'h1000_0010 : 32'h0000_0010,
            wdata: g ? 32'h1111_1111 : 32'h2222_2222, wstrb: g ? 4'hF : 4'h3});
        bus0.u_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_dreq("rr");
            if (k > 0) chk("rr_gap", 64'(cyc - last_ready_cyc), 64'd3);
            chk("fp_grant", 64'(bus1.grant), 64'd1);
            model_last = g;
            step();
            last_ready_cyc = cyc;
            resp_q.push_back(resp_t'{ready: g ? 2'b10 : 2'b01, error: 2'b00, rdata: 32'hA000_0000 + 32'(k)});
            pulse_dready(32'hA000_0000 + 32'(k), 1'b0);
            if (k == 3) begin
                bus0.u_req = 2'b00;
            end else begin
                g = ~model_last;
                issue_q.push_back(issue_t'{grant: g ? 2'b10 : 2'b01, wr: 1'b0,
                    addr: g ? 32'h1000_0010 : 32'h0000_0010,
                    wdata: g ? 32'h1111_1111 : 32'h2222_2222, wstrb: g ? 4'hF : 4'h3});
            end
        end
        wait_idle("rr");

        // Timeout after 8 BUSY cycles; read data forced to zero, stray d_ready afterwards ignored.
        step();
        bus0.u_req = 2'b01; bus0.u_wr = 2'b00;
        bus0.u_addr = {32'h0, 32'h0000_0300}; bus0.u_wdata = 64'h0; bus0.u_wstrb = 8'h00;
        bus0.d_rdata = 32'h5555_5555;
        issue_q.push_back(issue_t'{grant: 2'b01, wr: 1'b0, addr: 32'h0000_0300, wdata: 32'h0, wstrb: 4'h0});
        resp_q.push_back(resp_t'{ready: 2'b01, error: 2'b01, rdata: 32'h0});
        wait_dreq("to");
        step();
        bus0.u_req = 2'b00;
        n = 1;
        @(negedge clk);
        while (bus0.d_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("to_dreq_cycles", 64'(n), 64'd8);
        wait_idle("to");
        step();
        pulse_dready(32'h7777_7777, 1'b1);
        @(negedge clk);
        chk("stray_ready", 64'(bus0.u_ready), 64'd0);
        step();
        @(negedge clk);
        chk("stray_busy", 64'({bus0.busy, bus0.u_ready}), 64'd0);

        // Reset while BUSY discards the in-flight response.
        step();
        bus0.u_req = 2'b01;
        bus0.u_addr = {32'h0, 32'h0000_0400};
        issue_q.push_back(issue_t'{grant: 2'b01, wr: 1'b0, addr: 32'h0000_0400, wdata: 32'h0, wstrb: 4'h0});
        wait_dreq("rb");
        step();
        bus0.u_req = 2'b00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rb_dreq",  64'(bus0.d_req), 64'd0);
        chk("rb_grant", 64'(bus0.grant), 64'd0);
        chk("rb_busy",  64'(bus0.busy),  64'd0);
        step();
        pulse_dready(32'h9999_9999, 1'b0);
        @(negedge clk);
        chk("rb_no_ready", 64'(bus0.u_ready), 64'd0);
        step();
        @(negedge clk);
        chk("rb_no_ready2", 64'(bus0.u_ready), 64'd0);

        chk("issue_q_empty", 64'(issue_q.size()), 64'd0);
        chk("resp_q_empty",  64'(resp_q.size()),  64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
